// File: rtl/plaintext_validator.sv
`default_nettype none
// ============================================================================
// Module   : plaintext_validator
// Brief    : Checks one RC4-decrypted message for lowercase/space-only bytes,
//            raises sticky finish/fail and buffers the plaintext for readback.
//            Option macro: PLAINTEXT_VALIDATOR_EARLY_ABORT_EN (fail on the
//            first illegal byte instead of after the whole message).
// Revision : 1.0  initial release
// ============================================================================
module plaintext_validator #(
   parameter int MSG_LEN = 32,
   parameter int IDX_W   = $clog2(MSG_LEN)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   output logic             byte_ready,
   output logic             busy,
   output logic             finish,
   output logic             fail,
   output logic [IDX_W-1:0] bad_index,
   input  logic [IDX_W-1:0] rd_addr,
   output logic [7:0]       rd_data
);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_run  = 2'd1;
   localparam logic [1:0] c_st_pass = 2'd2;
   localparam logic [1:0] c_st_fail = 2'd3;

   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(MSG_LEN - 1);

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] count_q, count_d;
   logic [IDX_W-1:0] bad_idx_q, bad_idx_d;
   logic             seen_bad_q, seen_bad_d;
   logic [7:0]       rd_data_q;
   logic [7:0]       plain_mem [0:(2**IDX_W)-1];

   logic w_legal;
   logic w_accept;
   logic w_last;
   logic w_any_bad;

   assign w_legal   = (byte_data == 8'h20) ||
                      ((byte_data >= 8'h61) && (byte_data <= 8'h7A));
   // A start in the same cycle as a byte wins: the byte is dropped.
   assign w_accept  = (state_q == c_st_run) && byte_valid && !start;
   assign w_last    = (count_q == c_last_idx);
   assign w_any_bad = seen_bad_q || !w_legal;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= c_st_idle;
         count_q    <= '0;
         bad_idx_q  <= '0;
         seen_bad_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         bad_idx_q  <= bad_idx_d;
         seen_bad_q <= seen_bad_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = c_st_run;
      end else if (w_accept) begin
`ifdef PLAINTEXT_VALIDATOR_EARLY_ABORT_EN
         if (!w_legal) begin
            state_d = c_st_fail;
         end else if (w_last) begin
            state_d = seen_bad_q ? c_st_fail : c_st_pass;
         end
`else
         if (w_last) begin
            state_d = w_any_bad ? c_st_fail : c_st_pass;
         end
`endif
      end
   end

   always_comb begin
      count_d    = count_q;
      bad_idx_d  = bad_idx_q;
      seen_bad_d = seen_bad_q;
      if (start) begin
         count_d    = '0;
         bad_idx_d  = '0;
         seen_bad_d = 1'b0;
      end else if (w_accept) begin
         // The final byte leaves RUN, so the count is held rather than wrapped.
         if (!w_last) begin
            count_d = count_q + 1'b1;
         end
         if (!w_legal && !seen_bad_q) begin
            seen_bad_d = 1'b1;
            bad_idx_d  = count_q;
         end
      end
   end

   always_comb begin
      byte_ready = 1'b0;
      busy       = 1'b0;
      finish     = 1'b0;
      fail       = 1'b0;
      bad_index  = '0;
      case (state_q)
         c_st_run: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
         end
         c_st_pass: finish = 1'b1;
         c_st_fail: begin
            fail      = 1'b1;
            bad_index = bad_idx_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         plain_mem[count_q] <= byte_data;
      end
   end

   // Read-before-write: a same-cycle write to rd_addr returns the old byte.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= plain_mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_plaintext_validator.sv
`default_nettype none
// ============================================================================
// Module   : tb_plaintext_validator
// Brief    : Randomised scoreboard bench for plaintext_validator.
// Revision : 1.0  initial release
// ============================================================================
module tb_plaintext_validator;

   localparam int MSG_LEN = 32;
   localparam int IDX_W   = $clog2(MSG_LEN);
`ifdef PLAINTEXT_VALIDATOR_EARLY_ABORT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   typedef logic [7:0] msg_t [MSG_LEN];
   typedef struct {
      logic             fin;
      logic             fl;
      logic [IDX_W-1:0] bad;
   } res_t;

   logic             clk        = 1'b0;
   logic             reset      = 1'b1;
   logic             start      = 1'b0;
   logic             byte_valid = 1'b0;
   logic [7:0]       byte_data  = 8'h00;
   logic [IDX_W-1:0] rd_addr    = '0;
   logic             byte_ready;
   logic             busy;
   logic             finish;
   logic             fail;
   logic [IDX_W-1:0] bad_index;
   logic [7:0]       rd_data;

   int         n_cmp = 0;
   int         n_err = 0;
   res_t       exp_q [$];
   logic [7:0] rd_q  [$];
   logic [7:0] model [MSG_LEN];
   logic       rd_req    = 1'b0;
   logic       rd_req_p  = 1'b0;
   logic       prev_busy = 1'b0;

   plaintext_validator #(.MSG_LEN(MSG_LEN)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .busy       (busy),
      .finish     (finish),
      .fail       (fail),
      .bad_index  (bad_index),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_legal(input logic [7:0] b);
      return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
   endfunction

   function automatic int first_bad(input msg_t m);
      for (int i = 0; i < MSG_LEN; i++) begin
         if (!is_legal(m[i])) return i;
      end
      return -1;
   endfunction

   function automatic logic [7:0] rand_legal();
      int r = $urandom_range(0, 26);
      return (r == 26) ? 8'h20 : 8'(8'h61 + r);
   endfunction

   function automatic logic [7:0] rand_illegal();
      logic [7:0] b;
      do b = 8'($urandom); while (is_legal(b));
      return b;
   endfunction

   task automatic check_all_zero(input string tag);
      chk({tag, "_byte_ready"}, int'(byte_ready), 0);
      chk({tag, "_busy"},       int'(busy),       0);
      chk({tag, "_finish"},     int'(finish),     0);
      chk({tag, "_fail"},       int'(fail),       0);
      chk({tag, "_bad_index"},  int'(bad_index),  0);
      chk({tag, "_rd_data"},    int'(rd_data),    0);
   endtask

   // All driver tasks are entered and left on a falling edge.
   task automatic do_start();
      start      = 1'b1;
      byte_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("start_busy",   int'(busy),       1);
      chk("start_ready",  int'(byte_ready), 1);
      chk("start_finish", int'(finish),     0);
      chk("start_fail",   int'(fail),       0);
   endtask

   // mode 0: back-to-back, 1: valid toggles, 2: random idle gaps
   task automatic send_bytes(input msg_t m, input int lo, input int hi, input int mode);
      for (int i = lo; i < hi; i++) begin
         int gaps = (mode == 1 && i > lo) ? 1 : ((mode == 2) ? int'($urandom_range(0, 2)) : 0);
         repeat (gaps) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            @(negedge clk);
         end
         byte_valid = 1'b1;
         byte_data  = m[i];
         chk("ready_during_run", int'(byte_ready), 1);
         if (!byte_ready) begin
            byte_valid = 1'b0;
            return;
         end
         model[i] = m[i];
         @(negedge clk);
      end
      byte_valid = 1'b0;
   endtask

   task automatic send_msg(input msg_t m, input int mode, output int n_used);
      int   fb = first_bad(m);
      res_t e;
      n_used = (EARLY && fb >= 0) ? fb + 1 : MSG_LEN;
      e.fin  = (fb < 0);
      e.fl   = (fb >= 0);
      e.bad  = (fb < 0) ? '0 : IDX_W'(fb);
      exp_q.push_back(e);
      send_bytes(m, 0, n_used, mode);
      chk("busy_after_last",  int'(busy),       0);
      chk("ready_after_last", int'(byte_ready), 0);
   endtask

   task automatic read_back(input int lo, input int hi);
      for (int a = lo; a < hi; a++) begin
         rd_addr = IDX_W'(a);
         rd_req  = 1'b1;
         rd_q.push_back(model[a]);
         @(negedge clk);
      end
      rd_req = 1'b0;
      @(negedge clk);
   endtask

   always @(posedge clk) rd_req_p <= rd_req;

   initial begin : monitor
      res_t e;
      forever begin
         @(negedge clk);
         if (prev_busy && !busy && (finish || fail)) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL result: unexpected finish=%0b fail=%0b", finish, fail);
            end else begin
               e = exp_q.pop_front();
               chk("result_finish",    int'(finish),    int'(e.fin));
               chk("result_fail",      int'(fail),      int'(e.fl));
               chk("result_bad_index", int'(bad_index), int'(e.bad));
            end
         end
         if (rd_req_p) begin
            if (rd_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL rd_data: no expected read queued, got 0x%0h", rd_data);
            end else begin
               chk("rd_data", int'(rd_data), int'(rd_q.pop_front()));
            end
         end
         prev_busy = busy;
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : driver
      msg_t  m;
      int    n;
      int    a;
      string s;

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;
      @(negedge clk);
      chk("idle_busy",  int'(busy),       0);
      chk("idle_ready", int'(byte_ready), 0);

      s = "attack at dawn";
      for (int i = 0; i < MSG_LEN; i++) m[i] = (i < s.len()) ? s[i] : 8'h20;
      do_start();
      send_msg(m, 0, n);
      read_back(0, MSG_LEN);

      for (int i = 0; i < MSG_LEN; i++) m[i] = rand_legal();
      m[5] = 8'h60;
      m[9] = 8'h7B;
      do_start();
      send_msg(m, 0, n);
      byte_valid = 1'b1;
      byte_data  = 8'h61;
      repeat (10) begin
         @(negedge clk);
         chk("sticky_fail",      int'(fail),       1);
         chk("sticky_ready",     int'(byte_ready), 0);
         chk("sticky_bad_index", int'(bad_index),  5);
      end
      byte_valid = 1'b0;
      read_back(0, n);

      for (int i = 0; i < MSG_LEN; i++) m[i] = rand_legal();
      do_start();
      send_msg(m, 1, n);
      read_back(MSG_LEN - 4, MSG_LEN);

      for (int i = 0; i < MSG_LEN; i++) m[i] = rand_legal();
      do_start();
      send_bytes(m, 0, 10, 0);
      start      = 1'b1;
      byte_valid = 1'b1;
      byte_data  = 8'h41;
      @(negedge clk);
      start      = 1'b0;
      byte_valid = 1'b0;
      chk("restart_busy",  int'(busy),       1);
      chk("restart_ready", int'(byte_ready), 1);
      for (int i = 0; i < MSG_LEN; i++) m[i] = rand_legal();
      send_msg(m, 0, n);
      read_back(0, MSG_LEN);

      do_start();
      send_bytes(m, 0, 20, 0);
      #2 reset = 1'b1;
      #1 check_all_zero("async_reset");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < MSG_LEN; i++) m[i] = rand_legal();
      do_start();
      send_msg(m, 2, n);
      read_back(0, MSG_LEN);

      repeat (14) begin
         for (int i = 0; i < MSG_LEN; i++) m[i] = rand_legal();
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 2)) m[$urandom_range(0, MSG_LEN - 1)] = rand_illegal();
         end
         do_start();
         send_msg(m, int'($urandom_range(0, 2)), n);
         repeat (4) begin
            a = int'($urandom_range(0, n - 1));
            read_back(a, a + 1);
         end
      end

      repeat (3) @(negedge clk);
      chk("results_drained", exp_q.size(), 0);
      chk("reads_drained",   rd_q.size(),  0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/plaintext_validator.md
# plaintext_validator

Downstream checking stage for one RC4 decryption core in the key-search cracker. It consumes the decrypted byte stream for one candidate key and decides whether the plaintext is legal: every byte must be lowercase ASCII `a`–`z` (8'h61–8'h7A) or space (8'h20). It raises a sticky `finish` or `fail` level for the key-search controller. It also buffers the accepted plaintext so the message can be read back after a successful crack.

## Interface
Parameters:
- `MSG_LEN`, 32: bytes per message; legal range 2–256.
- `IDX_W`, `$clog2(MSG_LEN)`: width of index and address fields.

Ports (reset is asynchronous and active-high):
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous active-high reset.
- `start`  in  1  one-cycle pulse; begins a new check and clears all results.
- `byte_valid`  in  1  upstream presents a decrypted byte.
- `byte_data`  in  8  decrypted byte.
- `byte_ready`  out  1  block accepts a byte this cycle.
- `busy`  out  1  check in progress.
- `finish`  out  1  sticky; all `MSG_LEN` bytes were legal.
- `fail`  out  1  sticky; at least one illegal byte was seen.
- `bad_index`  out  IDX_W  index of the first illegal byte; 0 unless `fail`.
- `rd_addr`  in  IDX_W  plaintext buffer read address.
- `rd_data`  out  8  registered buffer read data.

## Operation
- State machine has four states: IDLE, RUN, PASS, FAIL.
  - IDLE, PASS and FAIL go to RUN on `start`.
  - RUN goes to PASS or FAIL as described below.
- Entering RUN clears `finish`, `fail` and `bad_index`, sets byte count to 0, and clears the seen-bad flag.
- A byte is accepted when `byte_valid && byte_ready` at a clock edge.
  - `byte_ready` = 1 only in RUN.
  - An accepted byte is written to `buf[count]`, and `count` increments.
- Legality check: `byte_data` == 8'h20, or 8'h61 ≤ `byte_data` ≤ 8'h7A. Every other value is illegal, including 8'h60, 8'h7B and uppercase letters.
- On the first illegal byte, `bad_index` latches `count`. Later illegal bytes do not change it.
- When byte index `MSG_LEN-1` is accepted:
  - go to FAIL if any byte, including this one, was illegal;
  - otherwise go to PASS.
- `finish` = 1 exactly in PASS. `fail` = 1 exactly in FAIL. `busy` = 1 exactly in RUN.
- `count` never wraps; the state leaves RUN on the final byte.
- `start` while in RUN aborts the current check and restarts it. A byte offered in the same cycle is discarded and not counted.
- The buffer is not reset. Bytes at indices ≥ the current `count` are stale.
- `rd_data` is valid in all states and reflects all completed writes. A read and write to the same address in one cycle returns the old data.
- `reset` at any time forces IDLE immediately and zeroes all outputs, even mid-message.

## Timing
- Reset values: `byte_ready`=0, `busy`=0, `finish`=0, `fail`=0, `bad_index`=0, `rd_data`=0.
- `start` sampled at edge N:
  - `busy`=1 and `byte_ready`=1 from cycle N+1;
  - `finish` and `fail` drop at N+1.
- Throughput: one byte per cycle when `byte_valid` is held high.
- Final byte accepted at edge M: `finish` or `fail` is visible from cycle M+1, `busy` drops at M+1, and `byte_ready` drops at M+1.
- Read latency: `rd_data` reflects `rd_addr` one cycle after it is sampled.

## Configuration
- `PLAINTEXT_VALIDATOR_EARLY_ABORT_EN` undefined:
  - the block always consumes all `MSG_LEN` bytes before deciding;
  - `fail` is not raised before the last byte.
- `PLAINTEXT_VALIDATOR_EARLY_ABORT_EN` defined:
  - an illegal byte accepted at edge M moves the state to FAIL at M+1;
  - `byte_ready` drops at M+1;
  - the remaining upstream bytes are not consumed.
  - This lets the controller advance to the next key early.
  - Buffer contents past the bad byte are stale.

## Test plan
- All legal: `start`, then 32 bytes "attack at dawn" padded with spaces, one per cycle → `finish`=1 one cycle after byte 31, `fail`=0, `busy`=0, `bad_index`=0; reading addresses 0–31 returns the message with 1-cycle latency.
- Boundary values: a message containing 8'h60 at index 5 and 8'h7B at index 9, with the other bytes legal.
  - Macro undefined → `fail`=1 after byte 31, `bad_index`=5.
  - Macro defined → `fail`=1 one cycle after byte 5, `byte_ready`=0, `bad_index`=5.
- Valid gaps: `byte_valid` toggles 1/0 each cycle → result appears one cycle after the 32nd accepted byte; `count` is unaffected by idle cycles.
- Restart mid-run: after 10 bytes, pulse `start` together with `byte_valid` → that byte is dropped; a further 32 legal bytes give `finish`=1; the buffer holds the new data.
- Reset mid-run: assert `reset` asynchronously after 20 bytes → all outputs go to 0 without waiting for a clock edge; a subsequent `start` plus 32 legal bytes gives `finish`=1.
- Sticky results: after `fail`=1, hold `byte_valid`=1 for 10 cycles with no `start` → `fail` stays 1, `byte_ready`=0, and `bad_index` is unchanged.
